// File: rtl/vga_frame_monitor_if.sv
// Video tap bus between a VGA source and vga_frame_monitor.
// master drives the connector-side signals and err_clr; slave (the monitor) returns status.
interface vga_frame_monitor_if #(
    parameter int unsigned BIT = 10
);
    logic           h_sync;
    logic           v_sync;
    logic [2:0]     rgb_in;
    logic           err_clr;
    logic           locked;
    logic           pixel_valid;
    logic [BIT-1:0] x_pos;
    logic [BIT-1:0] y_pos;
    logic           frame_done;
    logic [15:0]    frame_crc;
    logic [7:0]     frame_count;
    logic           err_line;
    logic           err_frame;

    modport master (
        output h_sync, v_sync, rgb_in, err_clr,
        input  locked, pixel_valid, x_pos, y_pos, frame_done,
        input  frame_crc, frame_count, err_line, err_frame
    );

    modport slave (
        input  h_sync, v_sync, rgb_in, err_clr,
        output locked, pixel_valid, x_pos, y_pos, frame_done,
        output frame_crc, frame_count, err_line, err_frame
    );
endinterface

// File: rtl/vga_frame_monitor.sv
// VGA receive-side monitor: recovers pixel coordinates from h_sync/v_sync,
// verifies line/frame periods, locks to the stream and signs each frame.
// Optional macro VGA_MON_PULSE_CHECK_EN adds sync pulse-width checks on trailing edges.
module vga_frame_monitor #(
    parameter int unsigned BIT             = 10,
    parameter int unsigned HRES            = 640,
    parameter int unsigned H_SYNC          = 96,
    parameter int unsigned H_BACK_PORCH    = 48,
    parameter int unsigned H_TOTAL         = 800,
    parameter int unsigned VRES            = 480,
    parameter int unsigned V_SYNC          = 2,
    parameter int unsigned V_BACK_PORCH    = 33,
    parameter int unsigned V_TOTAL         = 525,
    parameter int unsigned SYNC_ACTIVE_LOW = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    vga_frame_monitor_if.slave   bus
);
    localparam logic [BIT-1:0] H_START = BIT'(H_SYNC + H_BACK_PORCH);
    localparam logic [BIT-1:0] H_END   = BIT'(H_SYNC + H_BACK_PORCH + HRES);
    localparam logic [BIT-1:0] V_START = BIT'(V_SYNC + V_BACK_PORCH);
    localparam logic [BIT-1:0] V_END   = BIT'(V_SYNC + V_BACK_PORCH + VRES);
    localparam logic [BIT-1:0] H_LAST  = BIT'(H_TOTAL - 1);
    localparam logic [BIT-1:0] V_LAST  = BIT'(V_TOTAL - 1);

    typedef enum logic [1:0] {SEARCH, SYNCING, LOCKED} state_t;

    state_t         state, state_next;
    logic           hs_q, vs_q;
    logic [BIT-1:0] h_cnt, v_cnt;
    logic [15:0]    crc;

    logic           hs_c, vs_c, h_lead_c, v_lead_c;
    logic [BIT-1:0] h_next_c, v_next_c;
    logic           line_bad_c, frame_bad_c, active_c;
    logic           set_line_c, set_frame_c, done_c;
    logic [15:0]    crc_next_c;

    // Normalise sync polarity, find edges, compute post-edge counters and checks.
    always_comb begin
        hs_c        = (SYNC_ACTIVE_LOW != 0) ? ~bus.h_sync : bus.h_sync;
        vs_c        = (SYNC_ACTIVE_LOW != 0) ? ~bus.v_sync : bus.v_sync;
        h_lead_c    = hs_c & ~hs_q;
        v_lead_c    = vs_c & ~vs_q;
        h_next_c    = h_lead_c ? '0 : h_cnt + BIT'(1);
        v_next_c    = v_lead_c ? '0 : (h_lead_c ? v_cnt + BIT'(1) : v_cnt);
        line_bad_c  = h_lead_c && (h_cnt != H_LAST);
        frame_bad_c = v_lead_c && (v_cnt != V_LAST);
`ifdef VGA_MON_PULSE_CHECK_EN
        if (~hs_c && hs_q && (h_next_c != BIT'(H_SYNC))) line_bad_c  = 1'b1;
        if (~vs_c && vs_q && (v_next_c != BIT'(V_SYNC))) frame_bad_c = 1'b1;
`endif
        active_c    = (h_next_c >= H_START) && (h_next_c < H_END) &&
                      (v_next_c >= V_START) && (v_next_c < V_END);
        crc_next_c  = {crc[14:0], 1'b0} ^ (crc[15] ? 16'h1021 : 16'h0000) ^ {13'b0, bus.rgb_in};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= SEARCH;
        else       state <= state_next;
    end

    // Lock FSM: any failed check outside SEARCH flags and drops back to SEARCH.
    always_comb begin
        state_next  = state;
        set_line_c  = 1'b0;
        set_frame_c = 1'b0;
        done_c      = 1'b0;
        case (state)
            SEARCH: begin
                if (v_lead_c) state_next = SYNCING;
            end
            SYNCING, LOCKED: begin
                if (line_bad_c || frame_bad_c) begin
                    state_next  = SEARCH;
                    set_line_c  = line_bad_c;
                    set_frame_c = frame_bad_c;
                end else if (v_lead_c) begin
                    state_next = LOCKED;
                    done_c     = (state == LOCKED);
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    // Counters, signature, coordinates and sticky status.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_q            <= 1'b0;
            vs_q            <= 1'b0;
            h_cnt           <= '0;
            v_cnt           <= '0;
            crc             <= 16'hFFFF;
            bus.locked      <= 1'b0;
            bus.pixel_valid <= 1'b0;
            bus.x_pos       <= '0;
            bus.y_pos       <= '0;
            bus.frame_done  <= 1'b0;
            bus.frame_crc   <= '0;
            bus.frame_count <= '0;
            bus.err_line    <= 1'b0;
            bus.err_frame   <= 1'b0;
        end else begin
            hs_q            <= hs_c;
            vs_q            <= vs_c;
            h_cnt           <= h_next_c;
            v_cnt           <= v_next_c;
            bus.locked      <= (state_next == LOCKED);
            bus.pixel_valid <= active_c;
            bus.x_pos       <= active_c ? h_next_c - H_START : '0;
            bus.y_pos       <= active_c ? v_next_c - V_START : '0;
            bus.frame_done  <= done_c;
            if (v_lead_c)      crc <= 16'hFFFF;
            else if (active_c) crc <= crc_next_c;
            if (done_c) begin
                bus.frame_crc   <= crc;
                bus.frame_count <= bus.frame_count + 8'd1;
            end
            if (set_line_c)       bus.err_line <= 1'b1;
            else if (bus.err_clr) bus.err_line <= 1'b0;
            if (set_frame_c)      bus.err_frame <= 1'b1;
            else if (bus.err_clr) bus.err_frame <= 1'b0;
        end
    end
endmodule
